// File: rtl/sipo_receiver.sv
// sipo_receiver: serial-in/parallel-out frame receiver.
// Line format: idle 1, start bit 0, 8 data bits LSB first, stop bit 1.
// Each bit lasts CLKS_PER_BIT clocks. Bits are sampled at mid-bit, at offset
// H = (CLKS_PER_BIT-1)/2 from the clock edge where the start bit was first seen.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   serialIn serial line, same clock domain, idle 1
//   dataOut  last correctly framed byte; holds until the next good frame
//   valid    one-cycle pulse: dataOut was just updated
//   frameErr one-cycle pulse: the stop bit was sampled as 0
//   busy     high whenever the FSM is not in IDLE
module sipo_receiver #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serialIn,
  output logic [7:0] dataOut,
  output logic       valid,
  output logic       frameErr,
  output logic       busy
);

  localparam int         HALF   = (CLKS_PER_BIT - 1) / 2;
  localparam logic [7:0] N_M1   = 8'(CLKS_PER_BIT - 1);
  // START runs H edges after E0, so it is left when the counter reaches H-1.
  localparam logic [7:0] H_M1   = 8'((HALF > 0) ? HALF - 1 : 0);
  // With H=0 the start re-check would fall on E0 itself and cannot fail,
  // so IDLE goes straight to DATA.
  localparam bit         NO_CHK = (HALF == 0);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] bit_idx, bit_n;
  logic [7:0] shreg, sh_n;
  logic [7:0] data_n;
  logic       valid_n, err_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      dataOut  <= '0;
      valid    <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      shreg    <= sh_n;
      dataOut  <= data_n;
      valid    <= valid_n;
      frameErr <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    sh_n    = shreg;
    data_n  = dataOut;
    valid_n = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (!serialIn) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = NO_CHK ? DATA : START;
        end
      end
      START: begin
        if (cnt == H_M1) begin
          // Mid-start re-sample: a high line here was a glitch.
          cnt_n   = '0;
          bit_n   = '0;
          state_n = serialIn ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      DATA: begin
        if (cnt == N_M1) begin
          cnt_n = '0;
          // LSB first: shift right, new bit enters at the MSB.
          sh_n  = {serialIn, shreg[7:1]};
          if (bit_idx == 4'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 4'd1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      STOP: begin
        if (cnt == N_M1) begin
          cnt_n = '0;
          if (serialIn) begin
            data_n  = shreg;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      BREAK: begin
        // Wait out a held-low line; no start detection here.
        if (serialIn) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
